// File: rtl/render_sequencer.sv
// Frame-level scheduler for the mandelbrot_math pixel loop: one CLEAR pass, then MAX_PASSES
// iterate passes. Draw-mode changes are applied only at frame boundaries, which are found by counting pixel acks.
module render_sequencer #(
    parameter int FRAME_PIXELS = 384000,
    parameter int MAX_PASSES   = 127,
    parameter int PCNT_W       = 19
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Julia,
    input  logic       i_Px_Ack,
    output logic [1:0] o_Draw,
    output logic       o_Pause,
    output logic       o_Busy,
    output logic [7:0] o_Pass,
    output logic       o_Done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ITER
    } state_t;

    localparam logic [1:0]        DRAW_CLEAR      = 2'd0;
    localparam logic [1:0]        DRAW_MANDELBROT = 2'd1;
    localparam logic [1:0]        DRAW_JULIA      = 2'd2;
    localparam logic [PCNT_W-1:0] LAST_PIX        = PCNT_W'(FRAME_PIXELS - 1);
    localparam logic [7:0]        LAST_PASS       = 8'(MAX_PASSES);

    state_t            state_q, state_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]        pass_q, pass_d;
    logic              pend_q, pend_d;
    logic              julia_q, julia_d;
    logic [1:0]        draw_q, draw_d;
    logic              pause_q, pause_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic count_en;
    logic eof;
    logic [1:0] mode_code;

    // Acks that arrive while the loop is paused are not real pixels and must not move the counter.
    assign count_en  = !pause_q && i_Px_Ack;
    assign eof       = count_en && (pix_cnt_q == LAST_PIX);
    assign mode_code = julia_q ? DRAW_JULIA : DRAW_MANDELBROT;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        pass_d    = pass_q;
        pend_d    = pend_q;
        julia_d   = julia_q;
        draw_d    = draw_q;
        pause_d   = pause_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (count_en) begin
            pix_cnt_d = eof ? '0 : pix_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    julia_d = i_Julia;
                    state_d = ST_CLEAR;
                    draw_d  = DRAW_CLEAR;
                    pause_d = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 8'd0;
                end
            end

            ST_CLEAR, ST_ITER: begin
                if (i_Start) begin
                    pend_d  = 1'b1;
                    julia_d = i_Julia;
                end
                // A restart request (pending or arriving right now) overrides the normal frame transition.
                if (eof) begin
                    if (pend_q || i_Start) begin
                        state_d = ST_CLEAR;
                        pass_d  = 8'd0;
                        draw_d  = DRAW_CLEAR;
                        pend_d  = 1'b0;
                    end else if (state_q == ST_CLEAR) begin
                        state_d = ST_ITER;
                        pass_d  = 8'd1;
                        draw_d  = mode_code;
                    end else if (pass_q < LAST_PASS) begin
                        pass_d = pass_q + 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        pass_d  = 8'd0;
                        done_d  = 1'b1;
                        pause_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            pass_q    <= 8'd0;
            pend_q    <= 1'b0;
            julia_q   <= 1'b0;
            draw_q    <= DRAW_CLEAR;
            pause_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            pass_q    <= pass_d;
            pend_q    <= pend_d;
            julia_q   <= julia_d;
            draw_q    <= draw_d;
            pause_q   <= pause_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_Draw  = draw_q;
    assign o_Pause = pause_q;
    assign o_Busy  = busy_q;
    assign o_Pass  = pass_q;
    assign o_Done  = done_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer: a frame-schedule reference model is compared
// against the DUT every cycle under directed scenarios and randomized start/ack/reset traffic.
module tb_render_sequencer;

    localparam int FRAME = 16;
    localparam int MAXP  = 3;
    localparam int PW    = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       julia;
    logic       ack;
    logic [1:0] oDraw;
    logic       oPause;
    logic       oBusy;
    logic [7:0] oPass;
    logic       oDone;

    int checkCount = 0;
    int errorCount = 0;

    int clearCycles;
    int juliaCycles;
    int doneCount;

    // A render is a schedule of frames; each entry is the draw code and pass number for one frame.
    typedef struct {
        int draw;
        int pass;
    } frame_t;

    frame_t sched[$];
    int     mPix;
    bit     mPend;
    bit     mPendJulia;
    int     mDraw;
    int     mPass;
    bit     mPause;
    bit     mBusy;
    bit     mDone;

    render_sequencer #(
        .FRAME_PIXELS(FRAME),
        .MAX_PASSES  (MAXP),
        .PCNT_W      (PW)
    ) dut (
        .i_Clk   (clock),
        .i_Reset (reset),
        .i_Start (start),
        .i_Julia (julia),
        .i_Px_Ack(ack),
        .o_Draw  (oDraw),
        .o_Pause (oPause),
        .o_Busy  (oBusy),
        .o_Pass  (oPass),
        .o_Done  (oDone)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void loadRender(input bit j);
        frame_t f;
        sched.delete();
        f.draw = 0;
        f.pass = 0;
        sched.push_back(f);
        for (int p = 1; p <= MAXP; p++) begin
            f.draw = j ? 2 : 1;
            f.pass = p;
            sched.push_back(f);
        end
    endfunction

    function automatic void startFrame();
        frame_t f;
        f      = sched.pop_front();
        mDraw  = f.draw;
        mPass  = f.pass;
        mPause = 1'b0;
        mBusy  = 1'b1;
    endfunction

    // Reference behaviour: outputs after a clock edge given the inputs held during that edge.
    function automatic void stepModel(input bit s, input bit j, input bit a, input bit r);
        if (r) begin
            sched.delete();
            mPix   = 0;
            mPend  = 1'b0;
            mDraw  = 0;
            mPass  = 0;
            mPause = 1'b1;
            mBusy  = 1'b0;
            mDone  = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mPause) begin
                if (s) begin
                    loadRender(j);
                    startFrame();
                end
            end else begin
                if (s) begin
                    mPend      = 1'b1;
                    mPendJulia = j;
                end
                if (a) begin
                    mPix++;
                    if (mPix == FRAME) begin
                        mPix = 0;
                        if (mPend) begin
                            loadRender(mPendJulia);
                            mPend = 1'b0;
                            startFrame();
                        end else if (sched.size() == 0) begin
                            mDone  = 1'b1;
                            mPause = 1'b1;
                            mBusy  = 1'b0;
                            mPass  = 0;
                        end else begin
                            startFrame();
                        end
                    end
                end
            end
        end
    endfunction

    task automatic applyStimulus(input bit s, input bit j, input bit a, input bit r);
        start = s;
        julia = j;
        ack   = a;
        reset = r;
        @(posedge clock);
        stepModel(s, j, a, r);
        #1;
        checkOutput("draw", int'(oDraw), mDraw);
        checkOutput("pause", int'(oPause), int'(mPause));
        checkOutput("busy", int'(oBusy), int'(mBusy));
        checkOutput("pass", int'(oPass), mPass);
        checkOutput("done", int'(oDone), int'(mDone));
        if (!oPause && oDraw == 2'd0) clearCycles++;
        if (!oPause && oDraw == 2'd2) juliaCycles++;
        if (oDone) doneCount++;
    endtask

    task automatic clearTallies();
        clearCycles = 0;
        juliaCycles = 0;
        doneCount   = 0;
    endtask

    task automatic runUntilIdle(input int period, input int maxCycles);
        for (int c = 0; c < maxCycles && mBusy; c++) begin
            applyStimulus(1'b0, 1'b0, (c % period) == period - 1, 1'b0);
        end
        if (mBusy) checkOutput("idle_timeout", 1, 0);
    endtask

    initial begin
        start = 1'b0;
        julia = 1'b0;
        ack   = 1'b0;
        reset = 1'b1;
        clearTallies();

        // Reset, then stay idle with no acks.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_pause", int'(oPause), 1);
        checkOutput("reset_draw", int'(oDraw), 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_done_count", doneCount, 0);

        // Julia render with an ack every cycle.
        clearTallies();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("start_latency_pause", int'(oPause), 0);
        runUntilIdle(1, 200);
        checkOutput("julia_clear_cycles", clearCycles, 16);
        checkOutput("julia_iter_cycles", juliaCycles, 48);
        checkOutput("julia_done_count", doneCount, 1);

        // Mandelbrot render with an ack every third cycle.
        clearTallies();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runUntilIdle(3, 400);
        checkOutput("mandel_done_count", doneCount, 1);

        // Restart during pass 2 at pixel 5: only the second render completes.
        clearTallies();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && !(mPass == 2 && mPix == 5); c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_reach_pass", mPass, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_draw_hold", int'(oDraw), 2);
        runUntilIdle(1, 300);
        checkOutput("abort_done_count", doneCount, 1);

        // Start on the exact cycle of the final frame's last ack.
        clearTallies();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 200 && !(mPass == MAXP && mPix == FRAME - 1); c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("final_restart_draw", int'(oDraw), 0);
        checkOutput("final_restart_pass", int'(oPass), 0);
        checkOutput("final_restart_busy", int'(oBusy), 1);
        checkOutput("final_restart_done", doneCount, 0);
        runUntilIdle(1, 200);
        checkOutput("final_restart_done_after", doneCount, 1);

        // Reset in pass 1 at pixel 7, then a fresh render.
        clearTallies();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && !(mPass == 1 && mPix == 7); c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("midreset_busy", int'(oBusy), 0);
        checkOutput("midreset_pass", int'(oPass), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_restart_draw", int'(oDraw), 0);
        runUntilIdle(2, 300);

        // Randomized traffic, including acks while paused and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
